ppm_slot_modulator: RTL and testbench
=====================================

Name: ppm_slot_modulator

Overview:
- Downstream stage of the byte-to-dibit serializer; converts each 2-bit symbol into a 4-PPM optical pulse frame.
- Serializer holds each dibit for SYMBOL_CLKS clocks and asserts symbol_en while active. Its dibit output updates one clock after symbol_en rises or after a symbol boundary.
- This block keeps its own symbol-phase counter aligned to the serializer and emits one pulse per symbol in slot 0..3.
- It also reports completion, truncated symbols and a symbol count.

Parameters:
- SYMBOL_CLKS, 128, clocks per symbol; power of 2, at least 16; split into 4 equal slots of SLOT = SYMBOL_CLKS/4.
- PULSE_OFFSET, 2, clocks from slot start to pulse start; must be at least 2 so the symbol is latched before the slot-0 pulse.
- PULSE_WIDTH, 8, pulse length in clocks; at least 1; PULSE_OFFSET+PULSE_WIDTH must not exceed SLOT.
- CW, log2(SYMBOL_CLKS), phase counter width; derived.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- symbol_in  in  2  dibit from serializer; valid from phase 1 of each symbol
- symbol_en  in  1  serializer active; high continuously across back-to-back bytes
- err_clr  in  1  synchronous clear of underrun
- ppm_out  out  1  registered PPM pulse to laser driver
- ppm_active  out  1  registered copy of symbol_en
- symbol_done  out  1  1-cycle pulse per completed symbol
- underrun  out  1  sticky: symbol_en dropped mid-symbol
- symbols_sent  out  16  completed-symbol counter

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- On reset: ppm_out=0, ppm_active=0, symbol_done=0, underrun=0, symbols_sent=0, phase=0, sym_q=0.
- phase (CW bits):
  - While symbol_en=1, phase increments each clock and wraps SYMBOL_CLKS-1 -> 0 with no gap.
  - While symbol_en=0, phase loads 0.
  - Result: phase==0 in the first cycle symbol_en is high, matching the serializer's internal count.
- Symbol latch: when symbol_en=1 and phase==1, sym_q <= symbol_in. sym_q is held otherwise.
- Pulse decode (combinational):
  - hit = symbol_en and (phase[CW-1:CW-2] == sym_q) and (phase mod SLOT) in [PULSE_OFFSET, PULSE_OFFSET+PULSE_WIDTH-1].
  - ppm_out <= hit, so the output lags the decode by 1 clock.
  - Exactly one pulse of PULSE_WIDTH clocks per symbol; ppm_out is never high while symbol_en was low in the previous cycle.
- ppm_active <= symbol_en (1-clock latency).
- symbol_done <= symbol_en and (phase==SYMBOL_CLKS-1). It is high for one clock after the last phase of each symbol, back-to-back symbols included.
- symbols_sent increments on the same condition; 16-bit, wraps 0xFFFF -> 0x0000; cleared only by reset.
- Underrun:
  - Set when symbol_en=0 and phase!=0. This catches a drop mid-symbol; a normal end has phase==0 when symbol_en falls.
  - On underrun, phase forces to 0 and any in-progress pulse is cut on the next clock.
  - err_clr clears underrun; if set and clear occur in the same cycle, set wins.
- A truncated symbol gives no symbol_done and no count increment.
- symbol_en re-asserting the cycle after a drop starts a fresh symbol at phase 0.
- Async reset mid-pulse forces ppm_out=0 immediately.
- No other states: the block is idle (symbol_en=0, phase=0) or running.
- Total latency: symbol_en rise at cycle T gives the slot-s pulse at cycles T+SLOT*s+PULSE_OFFSET+1 .. T+SLOT*s+PULSE_OFFSET+PULSE_WIDTH.

Test Plan:
- Reset, then hold symbol_en=0 for 500 clocks -> all outputs stay 0; phase stays 0.
- Single byte 0xE4 (dibits 0,1,2,3), symbol_en high cycles T..T+511 with defaults:
  - ppm_out high at T+3..T+10, T+163..T+170, T+323..T+330, T+483..T+490.
  - symbol_done at T+128, T+256, T+384, T+512.
  - symbols_sent=4; underrun=0.
- Back-to-back bytes 0xFF then 0x00 with symbol_en continuous for 1024 clocks:
  - 4 pulses at phase 98..105 (slot 3), then 4 at phase 2..9 (slot 0).
  - No gap or double pulse at the byte boundary; symbols_sent=8.
- Drop symbol_en at phase 70 of a slot-2 symbol (pulse window phase 66..73):
  - ppm_out falls the clock after the drop; underrun=1; no symbol_done; symbols_sent unchanged.
  - Assert err_clr together with a second forced underrun -> underrun stays 1; err_clr alone -> 0.
- Preload symbols_sent to 0xFFFE via 2 ... run 3 symbols -> counter reads 0xFFFF, then 0x0000, then 0x0001.
- Assert rst_n low during a slot-1 pulse -> ppm_out=0 asynchronously and all state cleared; the next symbol_en rise restarts at phase 0 with correct pulse timing.

Source files
------------

// File: rtl/ppm_slot_modulator.sv
// ppm_slot_modulator
// Turns each 2-bit symbol from the byte-to-dibit serializer into a 4-PPM
// pulse frame. A local phase counter follows the serializer's symbol timing.
// The symbol is latched at phase 1. One pulse is emitted in slot 0..3,
// selected by the symbol.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_symbol_in    dibit from serializer (valid from phase 1 of each symbol)
//   i_symbol_en    serializer active, continuous across back-to-back bytes
//   i_err_clr      synchronous clear of the sticky underrun flag
//   o_ppm_out      registered PPM pulse to the laser driver
//   o_ppm_active   registered copy of i_symbol_en
//   o_symbol_done  one-cycle pulse per completed symbol
//   o_underrun     sticky: i_symbol_en dropped mid-symbol
//   o_symbols_sent completed-symbol counter (wraps)
module ppm_slot_modulator #(
  parameter int SYMBOL_CLKS  = 128,
  parameter int PULSE_OFFSET = 2,
  parameter int PULSE_WIDTH  = 8,
  parameter int CW           = $clog2(SYMBOL_CLKS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  i_symbol_in,
  input  logic        i_symbol_en,
  input  logic        i_err_clr,
  output logic        o_ppm_out,
  output logic        o_ppm_active,
  output logic        o_symbol_done,
  output logic        o_underrun,
  output logic [15:0] o_symbols_sent
);

  // Offset within a slot is the low CW-2 bits of the phase.
  localparam int SW = CW - 2;
  localparam logic [SW-1:0] WIN_LO = SW'(PULSE_OFFSET);
  localparam logic [SW-1:0] WIN_HI = SW'(PULSE_OFFSET + PULSE_WIDTH - 1);

  logic [CW-1:0] r_phase;
  logic [1:0]    r_sym_q;
  logic          r_ppm_out;
  logic          r_ppm_active;
  logic          r_symbol_done;
  logic          r_underrun;
  logic [15:0]   r_symbols_sent;

  logic [SW-1:0] w_slot_off;
  logic          w_hit;
  logic          w_last;
  logic          w_underrun_set;

  assign w_slot_off = r_phase[SW-1:0];
  assign w_hit = i_symbol_en
              && (r_phase[CW-1:CW-2] == r_sym_q)
              && (w_slot_off >= WIN_LO)
              && (w_slot_off <= WIN_HI);

  // SYMBOL_CLKS is a power of two, so the last phase is all ones.
  assign w_last = i_symbol_en && (&r_phase);

  // A normal end of transmission leaves phase at 0 when symbol_en falls.
  // Any other phase means the serializer stopped mid-symbol.
  assign w_underrun_set = !i_symbol_en && (r_phase != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase        <= '0;
      r_sym_q        <= '0;
      r_ppm_out      <= 1'b0;
      r_ppm_active   <= 1'b0;
      r_symbol_done  <= 1'b0;
      r_underrun     <= 1'b0;
      r_symbols_sent <= '0;
    end else begin
      // Wraps naturally at SYMBOL_CLKS-1 -> 0. Dropping symbol_en
      // (including an underrun) forces phase back to 0.
      r_phase <= i_symbol_en ? r_phase + CW'(1) : '0;

      if (i_symbol_en && (r_phase == CW'(1)))
        r_sym_q <= i_symbol_in;

      r_ppm_out     <= w_hit;
      r_ppm_active  <= i_symbol_en;
      r_symbol_done <= w_last;

      if (w_last)
        r_symbols_sent <= r_symbols_sent + 16'd1;

      // When set and clear occur in the same cycle, set wins.
      if (w_underrun_set)
        r_underrun <= 1'b1;
      else if (i_err_clr)
        r_underrun <= 1'b0;
    end
  end

  assign o_ppm_out      = r_ppm_out;
  assign o_ppm_active   = r_ppm_active;
  assign o_symbol_done  = r_symbol_done;
  assign o_underrun     = r_underrun;
  assign o_symbols_sent = r_symbols_sent;

endmodule

// File: tb/tb_ppm_slot_modulator.sv
module tb_ppm_slot_modulator;
  localparam int SC   = 128;
  localparam int SLOT = SC / 4;
  localparam int OFF  = 2;
  localparam int PW   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  symbol_in = 2'd0;
  logic        symbol_en = 1'b0;
  logic        err_clr = 1'b0;
  logic        o_ppm_out, o_ppm_active, o_symbol_done, o_underrun;
  logic [15:0] o_symbols_sent;

  ppm_slot_modulator dut (
    .clk(clk), .rst_n(rst_n),
    .i_symbol_in(symbol_in), .i_symbol_en(symbol_en), .i_err_clr(err_clr),
    .o_ppm_out(o_ppm_out), .o_ppm_active(o_ppm_active),
    .o_symbol_done(o_symbol_done), .o_underrun(o_underrun),
    .o_symbols_sent(o_symbols_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ppm;
    logic        act;
    logic        done;
    logic        ur;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   step_cyc = 0;

  // Reference model: run length since symbol_en rose, current symbol, flags.
  int          m_run = 0;
  logic [1:0]  m_sym = 2'd0;
  logic        m_ur = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  bit   log_en = 1'b0;
  int   rise_q[$];
  int   done_q[$];
  logic prev_ppm = 1'b0;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: observes every period just after the clock edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (log_en && o_ppm_out && !prev_ppm) rise_q.push_back(cyc);
      if (log_en && o_symbol_done) done_q.push_back(cyc);
      prev_ppm = o_ppm_out;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("ppm_out",      o_ppm_out,      mon_e.ppm);
        chk("ppm_active",   o_ppm_active,   mon_e.act);
        chk("symbol_done",  o_symbol_done,  mon_e.done);
        chk("underrun",     o_underrun,     mon_e.ur);
        chk("symbols_sent", o_symbols_sent, mon_e.cnt);
      end
    end
  end

  // Drive one period of inputs and predict the register values after the edge.
  task automatic step(input logic en, input logic [1:0] sym, input logic clr);
    int   ph;
    exp_t e;
    @(negedge clk);
    step_cyc  = cyc;
    symbol_en = en;
    symbol_in = sym;
    err_clr   = clr;
    ph = m_run % SC;
    e.ppm  = en && ((ph / SLOT) == int'(m_sym)) && ((ph % SLOT) >= OFF) && ((ph % SLOT) < OFF + PW);
    e.act  = en;
    e.done = en && (ph == SC - 1);
    if (e.done) m_cnt = m_cnt + 16'd1;
    if (!en && ph != 0) m_ur = 1'b1;
    else if (clr) m_ur = 1'b0;
    e.ur  = m_ur;
    e.cnt = m_cnt;
    if (en && ph == 1) m_sym = sym;
    m_run = en ? m_run + 1 : 0;
    sb_q.push_back(e);
  endtask

  // Drive n cycles of an active symbol; symbol_in carries garbage at phase 0.
  task automatic send_sym(input logic [1:0] d, input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, ((m_run % SC) >= 1) ? d : 2'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) send_sym(b[2*k +: 2], SC);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'($urandom_range(0, 3)), 1'b0);
  endtask

  int t0;
  logic [1:0] rsym;
  int n;

  initial begin
    // Reset state
    #12;
    chk("rst_ppm", o_ppm_out, 0);
    chk("rst_active", o_ppm_active, 0);
    chk("rst_done", o_symbol_done, 0);
    chk("rst_underrun", o_underrun, 0);
    chk("rst_count", o_symbols_sent, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: everything stays 0
    idle(500);

    // Single byte 0xE4 -> slots 0,1,2,3
    rise_q.delete(); done_q.delete(); log_en = 1'b1;
    send_byte(8'hE4);
    t0 = step_cyc - (SC * 4 - 1);
    idle(4);
    @(posedge clk); #2;
    chk("e4_pulses", rise_q.size(), 4);
    chk("e4_dones", done_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < rise_q.size()) chk("e4_rise", rise_q[k] - t0, 3 + 160 * k);
      if (k < done_q.size()) chk("e4_done", done_q[k] - t0, 128 * (k + 1));
    end
    chk("e4_count", o_symbols_sent, 4);
    chk("e4_underrun", o_underrun, 0);

    // Back-to-back 0xFF then 0x00, symbol_en continuous
    rise_q.delete(); done_q.delete();
    send_byte(8'hFF);
    t0 = step_cyc - (SC * 4 - 1);
    send_byte(8'h00);
    idle(4);
    @(posedge clk); #2;
    chk("b2b_pulses", rise_q.size(), 8);
    for (int k = 0; k < 8 && k < rise_q.size(); k++)
      chk("b2b_rise", rise_q[k] - t0, (k < 4) ? (99 + 128 * k) : (3 + 128 * k));
    chk("b2b_count", o_symbols_sent, 12);

    // Drop mid-pulse in slot 2 at phase 70
    done_q.delete();
    send_sym(2'd2, 70);
    step(1'b0, 2'd0, 1'b0);
    idle(3);
    @(posedge clk); #2;
    chk("drop_underrun", o_underrun, 1);
    chk("drop_no_done", done_q.size(), 0);
    chk("drop_count", o_symbols_sent, 12);
    send_sym(2'd1, 10);
    step(1'b0, 2'd0, 1'b1);
    idle(1);
    @(posedge clk); #2;
    chk("set_beats_clr", o_underrun, 1);
    step(1'b0, 2'd0, 1'b1);
    idle(1);
    @(posedge clk); #2;
    chk("clr_alone", o_underrun, 0);

    // Counter wrap: preload 0xFFFE while idle
    @(negedge clk);
    force dut.r_symbols_sent = 16'hFFFE;
    m_cnt = 16'hFFFE;
    idle(1);
    @(negedge clk);
    release dut.r_symbols_sent;
    send_sym(2'd3, SC);
    idle(1); @(posedge clk); #2;
    chk("wrap_ffff", o_symbols_sent, 16'hFFFF);
    send_sym(2'd0, SC);
    idle(1); @(posedge clk); #2;
    chk("wrap_0000", o_symbols_sent, 16'h0000);
    send_sym(2'd2, SC);
    idle(1); @(posedge clk); #2;
    chk("wrap_0001", o_symbols_sent, 16'h0001);

    // Async reset during a slot-1 pulse
    send_sym(2'd1, 38);
    @(posedge clk); #3;
    chk("pre_rst_ppm", o_ppm_out, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ppm", o_ppm_out, 0);
    chk("arst_active", o_ppm_active, 0);
    chk("arst_underrun", o_underrun, 0);
    chk("arst_count", o_symbols_sent, 0);
    m_run = 0; m_sym = 2'd0; m_ur = 1'b0; m_cnt = 16'd0;
    symbol_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    rise_q.delete(); done_q.delete();
    send_sym(2'd1, SC);
    t0 = step_cyc - (SC - 1);
    idle(3);
    @(posedge clk); #2;
    chk("post_rst_pulses", rise_q.size(), 1);
    if (rise_q.size() > 0) chk("post_rst_rise", rise_q[0] - t0, 35);
    chk("post_rst_count", o_symbols_sent, 1);

    // Randomized bursts: whole and truncated symbols, random err_clr
    log_en = 1'b0;
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 700);
      rsym = 2'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) begin
        if ((m_run % SC) == 0) rsym = 2'($urandom_range(0, 3));
        step(1'b1, ((m_run % SC) >= 1) ? rsym : 2'($urandom_range(0, 3)),
             ($urandom_range(0, 15) == 0));
      end
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++)
        step(1'b0, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end
    idle(3);
    @(posedge clk); #2;
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
